// File: rtl/m_sw_ctrl.sv
// Stopwatch run/pause/lap/clear controller.
// Turns synchronized button levels into rising-edge events, sequences the
// stopwatch FSM, prescales clk into a one-cycle count enable for the digit
// chain and issues a one-cycle synchronous clear to that chain.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stopped and cleared; ss starts, clr re-clears
//   RUN   | counting; ss pauses, lap freezes the display
//   PAUSE | stopped with partial tick kept; ss resumes, clr returns to IDLE
//   LAP   | counting with display frozen; lap resumes display, ss pauses
module m_sw_ctrl #(
   parameter int DIV   = 1000000,
   parameter int DIV_W = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       tick_en,
   output logic       cnt_clr,
   output logic       running,
   output logic       disp_hold,
   output logic [3:0] lap_cnt,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } st_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [3:0]       LAP_MAX  = 4'd9;

   st_t              st_q;
   st_t              st_d;
   logic             ss_q;
   logic             lap_q;
   logic             clr_q;
   logic             ss_rise;
   logic             lap_rise;
   logic             clr_rise;
   logic [3:0]       lap_cnt_q;
   logic [3:0]       lap_cnt_d;
   logic             clr_hon;
   logic [DIV_W-1:0] div_cnt;
   logic             counting;
   logic             div_wrap;

   assign ss_rise  = btn_ss  & ~ss_q;
   assign lap_rise = btn_lap & ~lap_q;
   assign clr_rise = btn_clr & ~clr_q;

   // Counting follows the pre-edge state, so a stop on a wrap edge still ticks.
   assign counting = (st_q == ST_RUN) || (st_q == ST_LAP);
   assign div_wrap = counting && (div_cnt == DIV_LAST);

   // Button history registers; reset to 1 so a button held through reset is not an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_q  <= 1'b1;
         lap_q <= 1'b1;
         clr_q <= 1'b1;
      end else begin
         ss_q  <= btn_ss;
         lap_q <= btn_lap;
         clr_q <= btn_clr;
      end
   end

   // State, lap counter and clear pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= ST_IDLE;
         lap_cnt_q <= 4'd0;
         cnt_clr   <= 1'b0;
      end else begin
         st_q      <= st_d;
         lap_cnt_q <= lap_cnt_d;
         cnt_clr   <= clr_hon;
      end
   end

   // Next-state decode; clr beats ss beats lap, and an ignored event never blocks a lower one.
   always_comb begin
      st_d      = st_q;
      lap_cnt_d = lap_cnt_q;
      clr_hon   = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (clr_rise) begin
               clr_hon   = 1'b1;
               lap_cnt_d = 4'd0;
            end else if (ss_rise) begin
               st_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ss_rise) begin
               st_d = ST_PAUSE;
            end else if (lap_rise) begin
               st_d      = ST_LAP;
               lap_cnt_d = (lap_cnt_q >= LAP_MAX) ? LAP_MAX : lap_cnt_q + 4'd1;
            end
         end
         ST_LAP: begin
            if (ss_rise) begin
               st_d = ST_PAUSE;
            end else if (lap_rise) begin
               st_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (clr_rise) begin
               st_d      = ST_IDLE;
               clr_hon   = 1'b1;
               lap_cnt_d = 4'd0;
            end else if (ss_rise) begin
               st_d = ST_RUN;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // Prescaler: advances while counting, holds in PAUSE, zeroed by an honored clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         tick_en <= 1'b0;
      end else begin
         tick_en <= div_wrap;
         if (clr_hon) begin
            div_cnt <= '0;
         end else if (counting) begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
         end
      end
   end

   assign running   = (st_q == ST_RUN) || (st_q == ST_LAP);
   assign disp_hold = (st_q == ST_LAP);
   assign lap_cnt   = lap_cnt_q;
   assign state     = st_q;

endmodule

// File: tb/tb_m_sw_ctrl.sv
// Scoreboard bench for m_sw_ctrl with DIV=4.
// The stimulus process pushes expected state snapshots and expected pulse
// cycles; the monitor process consumes them as the DUT presents outputs.
module tb_m_sw_ctrl;

   localparam int DIV   = 4;
   localparam int DIV_W = 3;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_ss;
   logic       btn_lap;
   logic       btn_clr;
   logic       tick_en;
   logic       cnt_clr;
   logic       running;
   logic       disp_hold;
   logic [3:0] lap_cnt;
   logic [1:0] state;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         k;
      logic [1:0] st;
      logic [3:0] lap;
      bit         quiet;
   } rec_t;

   rec_t exp_q[$];
   int   tick_q[$];
   int   clr_q[$];

   m_sw_ctrl #(.DIV(DIV), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_ss    (btn_ss),
      .btn_lap   (btn_lap),
      .btn_clr   (btn_clr),
      .tick_en   (tick_en),
      .cnt_clr   (cnt_clr),
      .running   (running),
      .disp_hold (disp_hold),
      .lap_cnt   (lap_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   // cyc == k during the cycle that follows posedge number k
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_st(input int k, input logic [1:0] st, input int lap, input bit quiet);
      rec_t r;
      r.k     = k;
      r.st    = st;
      r.lap   = 4'(lap);
      r.quiet = quiet;
      exp_q.push_back(r);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // buttons high so that the rise is sampled at posedge k, low again afterwards
   task automatic press_at(input int k, input logic s, input logic l, input logic c);
      wait_cyc(k - 1);
      btn_ss  = s;
      btn_lap = l;
      btn_clr = c;
      @(negedge clk);
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;
   endtask

   // monitor: state snapshots and pulse events, sampled mid-cycle
   always @(negedge clk) begin
      logic exp_run;
      logic exp_hold;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].k == cyc) begin
            exp_run  = (exp_q[i].st == S_RUN) || (exp_q[i].st == S_LAP);
            exp_hold = (exp_q[i].st == S_LAP);
            checks++;
            if (state !== exp_q[i].st || lap_cnt !== exp_q[i].lap ||
                running !== exp_run || disp_hold !== exp_hold ||
                (exp_q[i].quiet && (tick_en !== 1'b0 || cnt_clr !== 1'b0))) begin
               errors++;
               $display("FAIL snapshot cyc=%0d: got state=%b lap=%0d run=%b hold=%b tick=%b clr=%b, expected state=%b lap=%0d run=%b hold=%b%s",
                        cyc, state, lap_cnt, running, disp_hold, tick_en, cnt_clr,
                        exp_q[i].st, exp_q[i].lap, exp_run, exp_hold,
                        exp_q[i].quiet ? " tick=0 clr=0" : "");
            end
            exp_q.delete(i);
         end
      end
      while (tick_q.size() > 0 && tick_q[0] < cyc) begin
         checks++;
         errors++;
         $display("FAIL tick_missing: cycle %0d got tick_en=0, expected 1", tick_q[0]);
         void'(tick_q.pop_front());
      end
      if (tick_en === 1'b1) begin
         checks++;
         if (tick_q.size() > 0 && tick_q[0] == cyc) begin
            void'(tick_q.pop_front());
         end else begin
            errors++;
            $display("FAIL tick_unexpected: cycle %0d got tick_en=1, expected 0", cyc);
         end
      end
      while (clr_q.size() > 0 && clr_q[0] < cyc) begin
         checks++;
         errors++;
         $display("FAIL clr_missing: cycle %0d got cnt_clr=0, expected 1", clr_q[0]);
         void'(clr_q.pop_front());
      end
      if (cnt_clr === 1'b1) begin
         checks++;
         if (clr_q.size() > 0 && clr_q[0] == cyc) begin
            void'(clr_q.pop_front());
         end else begin
            errors++;
            $display("FAIL clr_unexpected: cycle %0d got cnt_clr=1, expected 0", cyc);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      btn_ss  = 1'b1;
      btn_lap = 1'b0;
      btn_clr = 1'b0;

      // reset with ss held: no event after release
      expect_st(2, S_IDLE, 0, 1'b1);
      expect_st(4, S_IDLE, 0, 1'b1);
      expect_st(6, S_IDLE, 0, 1'b1);
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(4);
      btn_ss = 1'b0;

      // start at edge 7, ticks every DIV cycles
      expect_st(7, S_RUN, 0, 1'b0);
      tick_q.push_back(11);
      tick_q.push_back(15);
      tick_q.push_back(19);
      press_at(7, 1'b1, 1'b0, 1'b0);

      // pause with residue 2, resume at 28: first tick two cycles later
      expect_st(21, S_PAUSE, 0, 1'b0);
      press_at(21, 1'b1, 1'b0, 1'b0);
      expect_st(28, S_RUN, 0, 1'b0);
      tick_q.push_back(30);
      tick_q.push_back(34);
      press_at(28, 1'b1, 1'b0, 1'b0);

      // clr in RUN ignored
      expect_st(31, S_RUN, 0, 1'b0);
      press_at(31, 1'b0, 1'b0, 1'b1);

      // ss+lap in RUN: pause, lap count unchanged
      expect_st(36, S_PAUSE, 0, 1'b0);
      press_at(36, 1'b1, 1'b1, 1'b0);

      // ss+clr in PAUSE: clear wins
      expect_st(39, S_IDLE, 0, 1'b0);
      clr_q.push_back(39);
      press_at(39, 1'b1, 1'b0, 1'b1);

      // clr in IDLE: pulse, stay IDLE
      expect_st(42, S_IDLE, 0, 1'b0);
      clr_q.push_back(42);
      press_at(42, 1'b0, 1'b0, 1'b1);

      // start at 45 (prescaler was cleared), pause at 47 with residue 2, resume at 49
      expect_st(45, S_RUN, 0, 1'b0);
      press_at(45, 1'b1, 1'b0, 1'b0);
      expect_st(47, S_PAUSE, 0, 1'b0);
      press_at(47, 1'b1, 1'b0, 1'b0);
      expect_st(49, S_RUN, 0, 1'b0);
      for (int j = 0; j < 14; j++) tick_q.push_back(51 + 4 * j);
      press_at(49, 1'b1, 1'b0, 1'b0);

      // lap in, clr ignored in LAP, lap out
      expect_st(56, S_LAP, 1, 1'b0);
      press_at(56, 1'b0, 1'b1, 1'b0);
      expect_st(58, S_LAP, 1, 1'b0);
      press_at(58, 1'b0, 1'b0, 1'b1);
      expect_st(61, S_RUN, 1, 1'b0);
      press_at(61, 1'b0, 1'b1, 1'b0);

      // ten more lap pairs: count saturates at 9
      for (int i = 0; i < 10; i++) begin
         expect_st(63 + 4 * i, S_LAP, (i + 2 > 9) ? 9 : i + 2, 1'b0);
         press_at(63 + 4 * i, 1'b0, 1'b1, 1'b0);
         expect_st(65 + 4 * i, S_RUN, (i + 2 > 9) ? 9 : i + 2, 1'b0);
         press_at(65 + 4 * i, 1'b0, 1'b1, 1'b0);
      end

      // lap with count at 9 still enters LAP
      expect_st(103, S_LAP, 9, 1'b0);
      expect_st(105, S_LAP, 9, 1'b0);
      press_at(103, 1'b0, 1'b1, 1'b0);

      // reset at the wrap edge 107 in LAP: no tick, back to IDLE
      expect_st(107, S_IDLE, 0, 1'b1);
      expect_st(112, S_IDLE, 0, 1'b1);
      wait_cyc(106);
      rst = 1'b1;
      wait_cyc(108);
      rst = 1'b0;
      wait_cyc(116);

      foreach (exp_q[i]) begin
         checks++;
         errors++;
         $display("FAIL snapshot_unchecked: cycle %0d never observed", exp_q[i].k);
      end
      foreach (tick_q[i]) begin
         checks++;
         errors++;
         $display("FAIL tick_missing: cycle %0d got no tick_en, expected 1", tick_q[i]);
      end
      foreach (clr_q[i]) begin
         checks++;
         errors++;
         $display("FAIL clr_missing: cycle %0d got no cnt_clr, expected 1", clr_q[i]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected end by cycle 116", cyc);
      $fatal(1, "watchdog");
   end

endmodule
